rr_lock_arbiter: RTL and testbench
==================================

// Module: rr_lock_arbiter
// PURPOSE
//  Round-robin arbiter with grant lock and hold timeout. One instance per read-only slave
//  shares the slave between ROMASTERS requesters.
//  Grant is combinational from request plus registered state, so a master can be granted in the
//  cycle it requests. The grant stays locked on the winner until the slave accepts (accept_i).
//  After an accept, priority rotates past the winner.
// PARAMETERS
//  NUM_PORTS  2   requesters, >=2; IDX_W = $clog2(NUM_PORTS) is a localparam
//  MAX_HOLD   16  cycles a locked, unaccepted grant may last; 0 = no timeout
//  CNT_W      8   hold counter width; requires MAX_HOLD < 2**CNT_W
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-low reset
//  request      in   NUM_PORTS  per-master request (address already decoded to this slave)
//  accept_i     in   1          slave accepts the granted request this cycle (slave gnt)
//  grant        out  NUM_PORTS  one-hot grant, or all-zero
//  grant_idx_o  out  IDX_W      index of the granted port; 0 when grant==0
//  grant_vld_o  out  1          |grant
//  timeout_o    out  1          registered one-cycle pulse: lock was force-released
//  prio_i       in   NUM_PORTS  high-priority flag per port (only with ARB_PRIO_EN)
// BEHAVIOUR
//  State (all registers): ptr[IDX_W], lock_vld, lock_idx[IDX_W], hold_cnt[CNT_W], timeout_o.
//  Reset (reset==0, async): all state 0. grant, grant_idx_o, grant_vld_o forced 0 while reset is low.
//  pick: first port p with request[p]=1, scanning ptr, ptr+1, ... cyclically modulo NUM_PORTS.
//  Grant selection, combinational:
//   - LOCKED (lock_vld=1 and request[lock_idx]=1): grant = onehot(lock_idx).
//   - Otherwise, if |request: grant = onehot(pick).
//   - Otherwise: grant = 0.
//   - A locked master that drops its request loses the lock in that same cycle; arbitration
//     proceeds normally.
//  Update at each posedge; let w = grant_idx_o.
//   - grant_vld_o & accept_i: ptr <= (w+1) mod NUM_PORTS; lock_vld <= 0; hold_cnt <= 0.
//   - grant_vld_o & !accept_i & MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1 (timeout):
//     ptr <= (w+1) mod NUM_PORTS; lock_vld <= 0; hold_cnt <= 0; timeout_o <= 1.
//   - grant_vld_o & !accept_i, no timeout: lock_vld <= 1; lock_idx <= w; hold_cnt <= hold_cnt+1.
//   - !grant_vld_o: lock_vld <= 0; hold_cnt <= 0; ptr unchanged.
//   - timeout_o <= 0 in every case except the timeout case.
//  accept_i while grant==0 is ignored.
//  Wrap-around: ptr at NUM_PORTS-1 after an accept wraps to 0.
//  hold_cnt saturates; it never wraps, because the timeout clears it first.
//  When a request changes while locked, only request[lock_idx] is considered.
//  Back-to-back accepts by one master alternate with the other requesters (fairness): no port
//  waits more than NUM_PORTS-1 accepts, or NUM_PORTS-1 timeouts.
//  Reset asserted mid-lock: lock is dropped immediately. After reset release, the first grant
//  uses ptr=0.
// CONFIGURATION
//  `ARB_PRIO_EN defined:
//   - prio_i port exists.
//   - pick scans only ports with request & prio_i when that set is non-zero; otherwise it scans
//     all requests.
//   - Rotation, lock and timeout rules are unchanged.
//   - A lock on a low-priority port is still honoured until accept, timeout or request drop.
//  Not defined: prio_i port absent; plain round-robin as above.
// TESTING (NUM_PORTS=4, MAX_HOLD=4 unless stated)
//  1. Reset, then request=4'b1111 with accept_i=1 every cycle:
//     grants 0001,0010,0100,1000,0001 on consecutive cycles.
//  2. request=4'b0100, accept_i=0 for 2 cycles then 1; at the accept edge request=4'b0101:
//     grant=0100 for 3 cycles, then 0001 (ptr=3 wraps to port 0).
//  3. Lock on port 1, request[1] drops while request[3]=1:
//     grant=1000 in the same cycle; lock_idx updates to 3 at the next edge.
//  4. request=4'b0011, accept_i=0 held:
//     grant=0001 for 4 cycles, timeout_o pulses 1 cycle, then grant=0010 for 4 cycles.
//     Repeat with MAX_HOLD=0: grant=0001 indefinitely, timeout_o never asserts.
//  5. Assert reset low mid-lock:
//     grant=0 asynchronously, timeout_o=0; after release with request=4'b1010, grant=0010.
//  6. With `ARB_PRIO_EN, request=4'b1111, prio_i=4'b1000, accept_i=1:
//     grant=1000 on every cycle; with prio_i=0, the sequence matches test 1.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant lock until accept and a hold timeout for one read-only slave.
// Optional feature: define ARB_PRIO_EN to add prio_i and restrict the pick to high-priority requesters.
module rr_lock_arbiter #(
  parameter  int NUM_PORTS = 2,
  parameter  int MAX_HOLD  = 16,
  parameter  int CNT_W     = 8,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] request,
  input  logic                 accept_i,
`ifdef ARB_PRIO_EN
  input  logic [NUM_PORTS-1:0] prio_i,
`endif
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_vld_o,
  output logic                 timeout_o
);

  logic [IDX_W-1:0]     ptr;
  logic                 lock_vld;
  logic [IDX_W-1:0]     lock_idx;
  logic [CNT_W-1:0]     hold_cnt;

  logic [NUM_PORTS-1:0] cand;
  logic [IDX_W-1:0]     pick_idx;
  logic                 locked;
  logic                 timeout_hit;
  logic [IDX_W-1:0]     next_ptr;

  // Candidate set: high-priority requesters win the scan when any are present.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand = request;
`ifdef ARB_PRIO_EN
    if (|(request & prio_i)) cand = request & prio_i;
`endif
    pick_idx = '0;
    // Scan offsets from far to near so the port closest to ptr is written last and wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand[(int'(ptr) + i) % NUM_PORTS]) pick_idx = IDX_W'((int'(ptr) + i) % NUM_PORTS);
    end
  end

  assign locked = lock_vld && request[lock_idx];

  always_comb begin
    grant       = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    if (reset) begin
      if (locked) begin
        grant_idx_o = lock_idx;
        grant_vld_o = 1'b1;
      end else if (|request) begin
        grant_idx_o = pick_idx;
        grant_vld_o = 1'b1;
      end
      if (grant_vld_o) grant[grant_idx_o] = 1'b1;
    end
  end

  assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign next_ptr    = (grant_idx_o == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_o + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
      hold_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      timeout_o <= 1'b0;
      if (!grant_vld_o) begin
        lock_vld <= 1'b0;
        hold_cnt <= '0;
      end else if (accept_i) begin
        ptr      <= next_ptr;
        lock_vld <= 1'b0;
        hold_cnt <= '0;
      end else if (timeout_hit) begin
        ptr       <= next_ptr;
        lock_vld  <= 1'b0;
        hold_cnt  <= '0;
        timeout_o <= 1'b1;
      end else begin
        lock_vld <= 1'b1;
        lock_idx <= grant_idx_o;
        // Only reachable without a timeout (MAX_HOLD=0); saturate instead of wrapping.
        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: directed scenarios plus random traffic against a
// behavioural model. Works with and without ARB_PRIO_EN defined.
module tb_rr_lock_arbiter;
  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int SAT  = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic         accept_i;
  logic [N-1:0] prio_i;
  logic [N-1:0] grant, grant_nt;
  logic [1:0]   grant_idx_o, grant_idx_nt;
  logic         grant_vld_o, grant_vld_nt;
  logic         timeout_o, timeout_nt;

  int checks = 0;
  int errors = 0;
  bit chk_nt = 1'b0;

  // Model state: rotation pointer, current lock owner (-1 = none), cycles held, timeout pulse.
  int m_ptr, m_owner, m_hold;
  bit m_tout;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.NUM_PORTS(N), .MAX_HOLD(HOLD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .request(request), .accept_i(accept_i),
`ifdef ARB_PRIO_EN
    .prio_i(prio_i),
`endif
    .grant(grant), .grant_idx_o(grant_idx_o), .grant_vld_o(grant_vld_o), .timeout_o(timeout_o)
  );

  rr_lock_arbiter #(.NUM_PORTS(N), .MAX_HOLD(0), .CNT_W(8)) dut_nt (
    .clk(clk), .reset(reset), .request(request), .accept_i(accept_i),
`ifdef ARB_PRIO_EN
    .prio_i(prio_i),
`endif
    .grant(grant_nt), .grant_idx_o(grant_idx_nt), .grant_vld_o(grant_vld_nt), .timeout_o(timeout_nt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected winner from the arbitration rules; -1 when nothing is granted.
  function automatic int model_winner(input logic [N-1:0] req, input logic [N-1:0] pr);
    logic [N-1:0] set;
    if (m_owner >= 0 && req[m_owner]) return m_owner;
    if (req == '0) return -1;
    set = req;
`ifdef ARB_PRIO_EN
    if ((req & pr) != '0) set = req & pr;
`endif
    for (int k = 0; k < N; k++)
      if (set[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_hold = 0; m_tout = 1'b0;
  endtask

  // One cycle: drive at negedge, check just after, advance the model at the posedge.
  task automatic step(input logic [N-1:0] req, input logic acc, input logic [N-1:0] pr,
                      input logic [N-1:0] exp_g, input bit use_exp, input string tag);
    int w;
    @(negedge clk);
    request = req; accept_i = acc; prio_i = pr;
    #1;
    w = model_winner(req, pr);
    check({tag, ".grant"},   grant,       (w < 0) ? 32'd0 : (32'd1 << w));
    check({tag, ".idx"},     grant_idx_o, (w < 0) ? 32'd0 : w);
    check({tag, ".vld"},     grant_vld_o, (w >= 0));
    check({tag, ".timeout"}, timeout_o,   m_tout);
    if (use_exp) check({tag, ".exp"}, grant, exp_g);
    if (chk_nt) begin
      check({tag, ".nt_grant"},   grant_nt,   32'd1);
      check({tag, ".nt_timeout"}, timeout_nt, 32'd0);
    end
    @(posedge clk);
    m_tout = 1'b0;
    if (w < 0) begin
      m_owner = -1; m_hold = 0;
    end else if (acc) begin
      m_ptr = (w + 1) % N; m_owner = -1; m_hold = 0;
    end else if (m_hold == HOLD - 1) begin
      m_ptr = (w + 1) % N; m_owner = -1; m_hold = 0; m_tout = 1'b1;
    end else begin
      m_owner = w;
      if (m_hold < SAT) m_hold++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; request = '0; accept_i = 1'b0; prio_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; request = '0; accept_i = 1'b0; prio_i = '0;
    model_reset();
    #2;
    check("rst.grant",   grant,       0);
    check("rst.idx",     grant_idx_o, 0);
    check("rst.vld",     grant_vld_o, 0);
    check("rst.timeout", timeout_o,   0);
    do_reset();

    // Full request with accept every cycle rotates 0,1,2,3 and wraps to 0.
    step(4'b1111, 1, 4'b0000, 4'b0001, 1, "t1");
    step(4'b1111, 1, 4'b0000, 4'b0010, 1, "t1");
    step(4'b1111, 1, 4'b0000, 4'b0100, 1, "t1");
    step(4'b1111, 1, 4'b0000, 4'b1000, 1, "t1");
    step(4'b1111, 1, 4'b0000, 4'b0001, 1, "t1");

    // Lock holds port 2 until accept; rotation then wraps past port 3 to port 0.
    do_reset();
    step(4'b0100, 0, 4'b0000, 4'b0100, 1, "t2");
    step(4'b0100, 0, 4'b0000, 4'b0100, 1, "t2");
    step(4'b0101, 1, 4'b0000, 4'b0100, 1, "t2");
    step(4'b0101, 1, 4'b0000, 4'b0001, 1, "t2");

    // Locked port 1 drops its request: port 3 wins in the same cycle.
    step(4'b0010, 0, 4'b0000, 4'b0010, 1, "t3");
    step(4'b1000, 0, 4'b0000, 4'b1000, 1, "t3");
    step(4'b1010, 0, 4'b0000, 4'b1000, 1, "t3");
    step(4'b1010, 1, 4'b0000, 4'b1000, 1, "t3");

    // Hold timeout after four unaccepted cycles; the no-timeout instance never lets go.
    do_reset();
    chk_nt = 1'b1;
    for (int i = 0; i < 4; i++) step(4'b0011, 0, 4'b0000, 4'b0001, 1, "t4");
    for (int i = 0; i < 4; i++) step(4'b0011, 0, 4'b0000, 4'b0010, 1, "t4");
    step(4'b0011, 0, 4'b0000, 4'b0001, 1, "t4");
    chk_nt = 1'b0;

    // Reset asserted mid-lock clears grant immediately; first grant afterwards uses ptr=0.
    do_reset();
    step(4'b0100, 0, 4'b0000, 4'b0100, 1, "t5");
    step(4'b0100, 0, 4'b0000, 4'b0100, 1, "t5");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5.rst_grant",   grant,       0);
    check("t5.rst_vld",     grant_vld_o, 0);
    check("t5.rst_idx",     grant_idx_o, 0);
    check("t5.rst_timeout", timeout_o,   0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(4'b1010, 0, 4'b0000, 4'b0010, 1, "t5");

`ifdef ARB_PRIO_EN
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1111, 1, 4'b1000, 4'b1000, 1, "t6");
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1111, 1, 4'b0000, 4'b0001 << (i % 4), 1, "t6");
`endif

    // Random traffic: accept roughly one cycle in three to exercise locks and timeouts.
    do_reset();
    for (int i = 0; i < 400; i++)
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), N'($urandom_range(0, 15)),
           4'b0000, 0, "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
